// File: rtl/i2s_dac_tx.sv
// i2s_dac_tx
// ----------
// Playback-side I2S transmitter for a WM8731 DAC. The codec is the I2S
// master: BCLK and DACLRCK are inputs. Samples come from the DSP through a
// request/valid handshake into a one-entry buffer. Each sample is sent
// MSB-first on both the left and right channels (mono).
//
// Handshake: o_ready is high while the buffer is empty. A sample is taken
// on any clock edge where i_en & i_dac_valid & o_ready are all high.
// o_request is a one-cycle hint that the DSP should supply the next sample.
// The DSP may also present valid data without a request, as long as
// o_ready is high.
//
// Ports:
//   i_clk         block clock (inverted AUD_BCLK: rising i_clk = falling BCLK)
//   i_rst         asynchronous active-high reset
//   i_en          playback enable; 0 forces IDLE and flushes the buffer
//   i_daclrck     codec DACLRCK (0 = left, 1 = right)
//   i_dac_data    DATA_W-bit two's-complement sample
//   i_dac_valid   i_dac_data is valid this cycle
//   o_ready       buffer empty
//   o_request     one-cycle pulse asking for the next sample
//   o_aud_dacdat  registered serial data to the codec
//   o_underrun    sticky: a left frame started with an empty buffer
//   o_dbg_state   current FSM state (0 IDLE, 1 WAIT, 2 SEND_L, 3 SEND_R)
module i2s_dac_tx #(
    parameter int DATA_W = 16,
    parameter int BCNT_W = 5
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic              i_daclrck,
    input  logic [DATA_W-1:0] i_dac_data,
    input  logic              i_dac_valid,
    output logic              o_ready,
    output logic              o_request,
    output logic              o_aud_dacdat,
    output logic              o_underrun,
    output logic [1:0]        o_dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_SEND_L = 2'd2,
        ST_SEND_R = 2'd3
    } state_t;

    localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(DATA_W - 1);
    localparam logic [BCNT_W-1:0] BCNT_SAT  = BCNT_W'(DATA_W);

    state_t              state_q, state_d;
    logic                lrck_q, lrck_d;
    logic [DATA_W-1:0]   buf_q, buf_d;
    logic                buf_full_q, buf_full_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic [DATA_W-1:0]   copy_q, copy_d;
    logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
    logic                dacdat_q, dacdat_d;
    logic                request_q, request_d;
    logic                underrun_q, underrun_d;

    logic                le;
    logic                re;
    logic                sending;
    logic                load_l;
    logic                load_r;
    logic                accept;
    logic [DATA_W-1:0]   word;

    // Channel edges from the registered LRCK copy.
    assign le      = lrck_q & ~i_daclrck;
    assign re      = ~lrck_q & i_daclrck;
    assign sending = (state_q == ST_SEND_L) || (state_q == ST_SEND_R);
    assign load_l  = i_en & le & (state_q != ST_IDLE);
    assign load_r  = i_en & re & sending;
    assign accept  = i_en & i_dac_valid & ~buf_full_q;
    // An empty buffer at the left edge sends a silent frame.
    assign word    = buf_full_q ? buf_q : '0;

    // ---------------- state register ----------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        if (!i_en) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:   state_d = ST_WAIT;
                ST_WAIT:   if (le) state_d = ST_SEND_L;
                ST_SEND_L,
                ST_SEND_R: begin
                    // A new edge abandons any unsent bits of a short half-frame.
                    if (le)      state_d = ST_SEND_L;
                    else if (re) state_d = ST_SEND_R;
                end
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    // ---------------- output / datapath logic ----------------
    always_comb begin
        lrck_d     = i_daclrck;
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        shift_d    = shift_q;
        copy_d     = copy_q;
        bcnt_d     = bcnt_q;
        dacdat_d   = 1'b0;
        request_d  = 1'b0;
        underrun_d = underrun_q;

        if (!i_en) begin
            buf_d      = '0;
            buf_full_d = 1'b0;
            shift_d    = '0;
            copy_d     = '0;
            bcnt_d     = '0;
            underrun_d = 1'b0;
        end else begin
            // Acceptance is evaluated against the old buffer state, so a
            // sample arriving on the left edge stays for the next frame.
            if (accept) begin
                buf_d      = i_dac_data;
                buf_full_d = 1'b1;
            end

            if (state_q == ST_IDLE) begin
                request_d = 1'b1;  // prefill request on enabling
            end else if (load_l) begin
                copy_d    = word;
                shift_d   = word << 1;
                dacdat_d  = word[DATA_W-1];
                bcnt_d    = '0;
                request_d = 1'b1;
                if (buf_full_q) begin
                    buf_d      = '0;
                    buf_full_d = 1'b0;
                end else begin
                    underrun_d = 1'b1;
                end
            end else if (load_r) begin
                shift_d  = copy_q << 1;
                dacdat_d = copy_q[DATA_W-1];
                bcnt_d   = '0;
            end else if (sending) begin
                // bcnt_q counts bits already sent after the MSB.
                if (bcnt_q < BCNT_LAST) begin
                    dacdat_d = shift_q[DATA_W-1];
                end
                shift_d = shift_q << 1;
                if (bcnt_q != BCNT_SAT) begin
                    bcnt_d = bcnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            lrck_q     <= 1'b1;
            buf_q      <= '0;
            buf_full_q <= 1'b0;
            shift_q    <= '0;
            copy_q     <= '0;
            bcnt_q     <= '0;
            dacdat_q   <= 1'b0;
            request_q  <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            lrck_q     <= lrck_d;
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
            shift_q    <= shift_d;
            copy_q     <= copy_d;
            bcnt_q     <= bcnt_d;
            dacdat_q   <= dacdat_d;
            request_q  <= request_d;
            underrun_q <= underrun_d;
        end
    end

    assign o_ready      = ~buf_full_q;
    assign o_request    = request_q;
    assign o_aud_dacdat = dacdat_q;
    assign o_underrun   = underrun_q;
    assign o_dbg_state  = state_q;

endmodule

// File: tb/tb_i2s_dac_tx.sv
module tb_i2s_dac_tx;

  localparam int DATA_W = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              en;
  logic              daclrck;
  logic [DATA_W-1:0] dac_data;
  logic              dac_valid;
  logic              ready;
  logic              request;
  logic              dacdat;
  logic              underrun;
  logic [1:0]        dbg_state;

  i2s_dac_tx #(.DATA_W(DATA_W), .BCNT_W(5)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_en         (en),
    .i_daclrck    (daclrck),
    .i_dac_data   (dac_data),
    .i_dac_valid  (dac_valid),
    .o_ready      (ready),
    .o_request    (request),
    .o_aud_dacdat (dacdat),
    .o_underrun   (underrun),
    .o_dbg_state  (dbg_state)
  );

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;

  int n_checks = 0;
  int n_fail   = 0;
  int req_cnt  = 0;
  int req_mark = 0;

  // Samples the DSP model hands out, one per o_request.
  logic [DATA_W-1:0] feed_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock; the DSP model answers o_request with a one-cycle valid.
  task automatic tick();
    @(posedge clk);
    #1;
    dac_valid = 1'b0;
    if (request === 1'b1) begin
      req_cnt++;
      if (feed_q.size() > 0) begin
        dac_data  = feed_q.pop_front();
        dac_valid = 1'b1;
      end
    end
  endtask

  task automatic send_bits(input string tag, input logic [DATA_W-1:0] w, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) begin
      tick();
      check(tag, {31'd0, dacdat}, {31'd0, w[i]});
    end
  endtask

  // One 32-clock half-frame: edge, 16 data bits, then 16 zero bits.
  task automatic half(input string tag, input logic lr, input logic [DATA_W-1:0] w);
    daclrck = lr;
    send_bits(tag, w, DATA_W - 1, 0);
    for (int i = 0; i < 16; i++) begin
      tick();
      check({tag, "_pad"}, {31'd0, dacdat}, 32'd0);
    end
  endtask

  task automatic frame(input string tag, input logic [DATA_W-1:0] w);
    req_mark = req_cnt;
    half({tag, "_L"}, 1'b0, w);
    half({tag, "_R"}, 1'b1, w);
    check({tag, "_reqs"}, req_cnt - req_mark, 32'd1);
  endtask

  initial begin
    en        = 1'b0;
    daclrck   = 1'b1;
    dac_data  = '0;
    dac_valid = 1'b0;

    // ---- reset values ----
    repeat (3) tick();
    check("rst_dacdat", {31'd0, dacdat}, 32'd0);
    check("rst_request", {31'd0, request}, 32'd0);
    check("rst_underrun", {31'd0, underrun}, 32'd0);
    check("rst_ready", {31'd0, ready}, 32'd1);
    check("rst_state", {30'd0, dbg_state}, {30'd0, S_IDLE});
    rst = 1'b0;
    tick();

    // ---- enable, prefill A5C3, then stream 8000 and 7FFF ----
    feed_q.push_back(16'hA5C3);
    feed_q.push_back(16'h8000);
    feed_q.push_back(16'h7FFF);
    en = 1'b1;
    tick();
    check("prefill_req", {31'd0, request}, 32'd1);
    check("prefill_state", {30'd0, dbg_state}, {30'd0, S_WAIT});
    tick();
    check("prefill_req_pulse", {31'd0, request}, 32'd0);
    check("prefill_ready", {31'd0, ready}, 32'd0);
    repeat (3) tick();
    check("wait_dacdat", {31'd0, dacdat}, 32'd0);
    frame("f1_a5c3", 16'hA5C3);
    check("f1_underrun", {31'd0, underrun}, 32'd0);
    frame("f2_8000", 16'h8000);
    frame("f3_7fff", 16'h7FFF);
    check("f3_underrun", {31'd0, underrun}, 32'd0);

    // ---- underrun: nothing supplied for frame 4 ----
    frame("f4_under", 16'h0000);
    check("f4_underrun", {31'd0, underrun}, 32'd1);
    dac_data  = 16'h1234;
    dac_valid = 1'b1;
    tick();
    check("late_ready", {31'd0, ready}, 32'd0);
    frame("f5_1234", 16'h1234);
    check("f5_underrun_sticky", {31'd0, underrun}, 32'd1);

    // ---- i_en=0 clears the underrun flag ----
    en = 1'b0;
    tick();
    check("dis_underrun", {31'd0, underrun}, 32'd0);
    check("dis_state", {30'd0, dbg_state}, {30'd0, S_IDLE});
    check("dis_ready", {31'd0, ready}, 32'd1);
    en = 1'b1;
    tick();
    check("reen_req", {31'd0, request}, 32'd1);
    repeat (2) tick();

    // ---- sample offered in the same cycle as LE with empty buffer ----
    dac_data  = 16'hBEEF;
    dac_valid = 1'b1;
    frame("f6_lecoll", 16'h0000);
    check("f6_underrun", {31'd0, underrun}, 32'd1);
    check("f6_ready", {31'd0, ready}, 32'd0);
    feed_q.push_back(16'h0F0F);
    frame("f7_beef", 16'hBEEF);

    // ---- drop i_en while bit 7 is on the line ----
    feed_q.push_back(16'h5555);
    daclrck = 1'b0;
    send_bits("f8_0f0f", 16'h0F0F, 15, 7);
    check("f8_ready_full", {31'd0, ready}, 32'd0);
    en = 1'b0;
    tick();
    check("drop_dacdat", {31'd0, dacdat}, 32'd0);
    check("drop_ready", {31'd0, ready}, 32'd1);
    check("drop_state", {30'd0, dbg_state}, {30'd0, S_IDLE});
    check("drop_request", {31'd0, request}, 32'd0);

    // ---- re-enable: prefill and wait for a left edge ----
    feed_q.push_back(16'h3C3C);
    en = 1'b1;
    tick();
    check("reen2_req", {31'd0, request}, 32'd1);
    check("reen2_state", {30'd0, dbg_state}, {30'd0, S_WAIT});
    daclrck = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("reen2_wait_dacdat", {31'd0, dacdat}, 32'd0);
    end
    check("reen2_still_wait", {30'd0, dbg_state}, {30'd0, S_WAIT});

    // ---- reset in the middle of a word ----
    daclrck = 1'b0;
    send_bits("f9_3c3c", 16'h3C3C, 15, 10);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_dacdat", {31'd0, dacdat}, 32'd0);
    check("async_rst_request", {31'd0, request}, 32'd0);
    check("async_rst_underrun", {31'd0, underrun}, 32'd0);
    check("async_rst_ready", {31'd0, ready}, 32'd1);
    check("async_rst_state", {30'd0, dbg_state}, {30'd0, S_IDLE});
    en = 1'b0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("post_rst_dacdat", {31'd0, dacdat}, 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
